// File: rtl/mc_controller_pkg.sv
// mc_controller_pkg
//   Shared encodings for the multi-cycle MIPS32 control unit: opcode/funct
//   constants, FSM state codes, ALU op, next-PC select, register destination
//   and write-data select codes, and the instruction-class index map used by
//   the decoder's one-hot output.
package mc_controller_pkg;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_JAL   = 6'h03;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_LUI   = 6'h0F;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    // ALU operations
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_SRA = 3'b100;

    // Next-PC sources
    localparam logic [2:0] NPC_PC4  = 3'b000;
    localparam logic [2:0] NPC_BEQ  = 3'b001;
    localparam logic [2:0] NPC_J    = 3'b010;
    localparam logic [2:0] NPC_JAL  = 3'b011;
    localparam logic [2:0] NPC_JR   = 3'b100;
    localparam logic [2:0] NPC_JALR = 3'b101;

    // Register destination select
    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    // Register write-data select
    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MDR = 2'b01;
    localparam logic [1:0] WD_PC  = 2'b10;
    localparam logic [1:0] WD_LUI = 2'b11;

    // Bit positions of the one-hot instruction class vector
    localparam int CLS_ADDU = 0;
    localparam int CLS_SUBU = 1;
    localparam int CLS_SRA  = 2;
    localparam int CLS_ORI  = 3;
    localparam int CLS_LUI  = 4;
    localparam int CLS_LW   = 5;
    localparam int CLS_SW   = 6;
    localparam int CLS_BEQ  = 7;
    localparam int CLS_J    = 8;
    localparam int CLS_JAL  = 9;
    localparam int CLS_JR   = 10;
    localparam int CLS_JALR = 11;
    localparam int N_CLS    = 12;

    // Register-register ALU instructions share EXEC/WB handling
    function automatic logic is_alu_r(input logic [N_CLS-1:0] cls);
        return cls[CLS_ADDU] | cls[CLS_SUBU] | cls[CLS_SRA];
    endfunction

endpackage

// File: rtl/mc_controller_instr_decode.sv
// mc_controller_instr_decode
//   Combinational instruction classifier.
//   Ports:
//     opc     in  6       primary opcode IR[31:26]
//     func    in  6       function field IR[5:0] (only meaningful for opc 0)
//     cls     out N_CLS   one-hot instruction class (all zero when illegal)
//     illegal out 1       opcode/funct combination not supported
module mc_controller_instr_decode
    import mc_controller_pkg::*;
(
    input  logic [5:0]       opc,
    input  logic [5:0]       func,
    output logic [N_CLS-1:0] cls,
    output logic             illegal
);

    always_comb begin
        cls = '0;
        case (opc)
            OPC_RTYPE: begin
                case (func)
                    FN_ADDU: cls[CLS_ADDU] = 1'b1;
                    FN_SUBU: cls[CLS_SUBU] = 1'b1;
                    FN_SRA:  cls[CLS_SRA]  = 1'b1;
                    FN_JR:   cls[CLS_JR]   = 1'b1;
                    FN_JALR: cls[CLS_JALR] = 1'b1;
                    default: cls = '0;
                endcase
            end
            OPC_ORI: cls[CLS_ORI] = 1'b1;
            OPC_LUI: cls[CLS_LUI] = 1'b1;
            OPC_LW:  cls[CLS_LW]  = 1'b1;
            OPC_SW:  cls[CLS_SW]  = 1'b1;
            OPC_BEQ: cls[CLS_BEQ] = 1'b1;
            OPC_J:   cls[CLS_J]   = 1'b1;
            OPC_JAL: cls[CLS_JAL] = 1'b1;
            default: cls = '0;
        endcase
        illegal = ~|cls;
    end

endmodule

// File: rtl/mc_controller.sv
// mc_controller
//   Multi-cycle MIPS32 control unit. Sequences FETCH/DECODE/EXEC/MEM/WB over a
//   shared memory with a ready handshake and drives the datapath strobes.
//   Counts retired instructions and raises a sticky fault on an illegal
//   instruction or a memory access that waits MEM_TIMEOUT cycles.
//   Ports:
//     clk, rst_n            clock (rising edge), async active-low reset
//     opc, func, zero       instruction fields and ALU equal flag
//     mem_ready             memory completes the current access this cycle
//     memread, memwrite     memory requests; iord picks PC (0) or ALUOut (1)
//     irwrite, pcwrite      IR latch and PC load; npc_slc picks next PC
//     regwrite, regdst,     register-file write enable, destination and
//     wd_sel                write-data source
//     alusrc, extop, aluop  ALU operand B select, immediate extension, op
//     state                 current FSM state (debug)
//     fault                 sticky fault flag
//     retired               retired-instruction count, wraps
module mc_controller
    import mc_controller_pkg::*;
#(
    parameter int ALUOP_W     = 3,
    parameter int NPC_W       = 3,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opc,
    input  logic [5:0]         func,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               memread,
    output logic               memwrite,
    output logic               iord,
    output logic               irwrite,
    output logic               pcwrite,
    output logic [NPC_W-1:0]   npc_slc,
    output logic               regwrite,
    output logic [1:0]         regdst,
    output logic [1:0]         wd_sel,
    output logic               alusrc,
    output logic               extop,
    output logic [ALUOP_W-1:0] aluop,
    output logic [2:0]         state,
    output logic               fault,
    output logic [CNT_W-1:0]   retired
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t              state_q;
    state_t              state_next;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [N_CLS-1:0]    cls;
    logic                illegal;
    logic                wait_hit;
    logic                waiting;
    logic                retire;

    mc_controller_instr_decode u_decode (
        .opc     (opc),
        .func    (func),
        .cls     (cls),
        .illegal (illegal)
    );

    // The access that has already waited MEM_TIMEOUT-1 cycles faults on its
    // next not-ready cycle; mem_ready in that same cycle still completes it.
    assign wait_hit = (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));
    assign waiting  = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;
    assign retire   = (state_next == S_FETCH) &&
                      (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB});
    assign state    = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            fault    <= 1'b0;
            retired  <= '0;
            wait_cnt <= '0;
        end else begin
            state_q <= state_next;
            if (state_next == S_FAULT) begin
                fault <= 1'b1;
            end
            // Any state change clears the counter, so every FETCH/MEM entry
            // starts a fresh wait budget.
            if (state_next != state_q) begin
                wait_cnt <= '0;
            end else if (waiting) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            if (retire) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

    // Outputs are forced low while rst_n is asserted so that no write can
    // leak out during an asynchronous reset.
    always_comb begin
        state_next = state_q;
        memread    = 1'b0;
        memwrite   = 1'b0;
        iord       = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        npc_slc    = NPC_W'(NPC_PC4);
        regwrite   = 1'b0;
        regdst     = RD_RT;
        wd_sel     = WD_ALU;
        alusrc     = 1'b0;
        extop      = 1'b0;
        aluop      = '0;

        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    memread = 1'b1;
                    if (mem_ready) begin
                        irwrite    = 1'b1;
                        pcwrite    = 1'b1;
                        npc_slc    = NPC_W'(NPC_PC4);
                        state_next = S_DECODE;
                    end else if (wait_hit) begin
                        state_next = S_FAULT;
                    end
                end

                S_DECODE: begin
                    if (illegal) begin
                        state_next = S_FAULT;
                    end else if (cls[CLS_J]) begin
                        pcwrite    = 1'b1;
                        npc_slc    = NPC_W'(NPC_J);
                        state_next = S_FETCH;
                    end else if (cls[CLS_JAL]) begin
                        pcwrite    = 1'b1;
                        npc_slc    = NPC_W'(NPC_JAL);
                        regwrite   = 1'b1;
                        regdst     = RD_RA;
                        wd_sel     = WD_PC;
                        state_next = S_FETCH;
                    end else if (cls[CLS_JR]) begin
                        pcwrite    = 1'b1;
                        npc_slc    = NPC_W'(NPC_JR);
                        state_next = S_FETCH;
                    end else if (cls[CLS_JALR]) begin
                        pcwrite    = 1'b1;
                        npc_slc    = NPC_W'(NPC_JALR);
                        regwrite   = 1'b1;
                        regdst     = RD_RD;
                        wd_sel     = WD_PC;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_EXEC;
                    end
                end

                S_EXEC: begin
                    if (is_alu_r(cls)) begin
                        alusrc     = 1'b0;
                        if (cls[CLS_ADDU]) aluop = ALUOP_W'(ALU_ADD);
                        if (cls[CLS_SUBU]) aluop = ALUOP_W'(ALU_SUB);
                        if (cls[CLS_SRA])  aluop = ALUOP_W'(ALU_SRA);
                        state_next = S_WB;
                    end else if (cls[CLS_ORI]) begin
                        alusrc     = 1'b1;
                        extop      = 1'b0;
                        aluop      = ALUOP_W'(ALU_OR);
                        state_next = S_WB;
                    end else if (cls[CLS_LUI]) begin
                        alusrc     = 1'b1;
                        state_next = S_WB;
                    end else if (cls[CLS_LW] || cls[CLS_SW]) begin
                        alusrc     = 1'b1;
                        extop      = 1'b1;
                        aluop      = ALUOP_W'(ALU_ADD);
                        state_next = S_MEM;
                    end else if (cls[CLS_BEQ]) begin
                        alusrc     = 1'b0;
                        extop      = 1'b1;
                        aluop      = ALUOP_W'(ALU_SUB);
                        pcwrite    = zero;
                        npc_slc    = NPC_W'(NPC_BEQ);
                        state_next = S_FETCH;
                    end else begin
                        // Opcode changed under us; nothing sane to execute.
                        state_next = S_FAULT;
                    end
                end

                S_MEM: begin
                    iord = 1'b1;
                    if (cls[CLS_LW] || cls[CLS_SW]) begin
                        memread  = cls[CLS_LW];
                        memwrite = cls[CLS_SW];
                        if (mem_ready) begin
                            state_next = cls[CLS_LW] ? S_WB : S_FETCH;
                        end else if (wait_hit) begin
                            state_next = S_FAULT;
                        end
                    end else begin
                        state_next = S_FAULT;
                    end
                end

                S_WB: begin
                    state_next = S_FETCH;
                    regwrite   = 1'b1;
                    if (is_alu_r(cls)) begin
                        regdst = RD_RD;
                        wd_sel = WD_ALU;
                    end else if (cls[CLS_LUI]) begin
                        wd_sel = WD_LUI;
                    end else if (cls[CLS_LW]) begin
                        wd_sel = WD_MDR;
                    end else if (cls[CLS_ORI]) begin
                        wd_sel = WD_ALU;
                    end else begin
                        regwrite   = 1'b0;
                        state_next = S_FAULT;
                    end
                end

                S_FAULT: state_next = S_FAULT;

                default: state_next = S_FAULT;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
module tb_mc_controller;

    localparam int CW = 4;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [5:0]    opc = '0;
    logic [5:0]    func = '0;
    logic          zero = 1'b0;
    logic          mem_ready = 1'b0;
    logic          memread, memwrite, iord, irwrite, pcwrite, regwrite;
    logic [2:0]    npc_slc, aluop, state;
    logic [1:0]    regdst, wd_sel;
    logic          alusrc, extop, fault;
    logic [CW-1:0] retired;

    mc_controller #(.ALUOP_W(3), .NPC_W(3), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .opc(opc), .func(func), .zero(zero),
        .mem_ready(mem_ready), .memread(memread), .memwrite(memwrite),
        .iord(iord), .irwrite(irwrite), .pcwrite(pcwrite), .npc_slc(npc_slc),
        .regwrite(regwrite), .regdst(regdst), .wd_sel(wd_sel), .alusrc(alusrc),
        .extop(extop), .aluop(aluop), .state(state), .fault(fault),
        .retired(retired)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int model_ret = 0;

    // Instruction kinds for the reference model
    localparam int K_ALU = 0, K_JMP = 1, K_BEQ = 2, K_LW = 3, K_SW = 4;

    typedef struct {
        logic [5:0] opc;
        logic [5:0] func;
        int         kind;
        logic       rw;
        logic [1:0] rd;
        logic [1:0] wd;
        logic [2:0] npc;
        logic [2:0] aop;
        logic       chk_aop;
        logic       asrc;
        logic       ext;
        logic       chk_ext;
    } ins_t;

    typedef struct {
        logic [5:0] opc;
        logic [5:0] func;
        logic       pcw;
        logic [2:0] npc;
        logic       rw;
        logic [1:0] rd;
        logic [1:0] wd;
        logic [2:0] nxt;
    } dvec_t;

    ins_t  itab [12];
    dvec_t dtab [11];

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds reset across two edges and releases it just after an edge, so
    // the first active edge follows with whatever inputs the caller sets.
    task automatic do_reset();
        rst_n = 1'b0;
        mem_ready = 1'b0;
        zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_ret = 0;
    endtask

    function automatic int strobes();
        return int'(memread) + int'(memwrite) + int'(irwrite) + int'(pcwrite) + int'(regwrite);
    endfunction

    // Runs one instruction from FETCH back to FETCH. fw/mw = not-ready cycles
    // before the fetch / data access completes; zx = zero flag in EXEC.
    task automatic run_instr(input int idx, input int fw, input int mw, input logic zx);
        ins_t  it;
        string nm;
        int    total, exec_c, mem_lo, mem_hi;
        int    n_rd, n_wr, n_io, n_ir, n_pc, n_rw;
        int    last_npc, rd_s, wd_s, exp_pc, exp_npc, exp_rd;
        bit    is_mem;
        it = itab[idx];
        nm = $sformatf("ins%0d_fw%0d_mw%0d", idx, fw, mw);
        opc = it.opc;
        func = (it.opc == 6'h00) ? it.func : 6'($urandom);
        is_mem = (it.kind == K_LW) || (it.kind == K_SW);
        exec_c = fw + 2;
        mem_lo = fw + 3;
        mem_hi = fw + 3 + mw;
        case (it.kind)
            K_JMP:   total = fw + 2;
            K_BEQ:   total = fw + 3;
            K_SW:    total = fw + mw + 4;
            K_LW:    total = fw + mw + 5;
            default: total = fw + 4;
        endcase
        n_rd = 0; n_wr = 0; n_io = 0; n_ir = 0; n_pc = 0; n_rw = 0;
        last_npc = -1; rd_s = -1; wd_s = -1;
        for (int c = 0; c < total; c++) begin
            @(negedge clk);
            if (c < fw)                     mem_ready = 1'b0;
            else if (c == fw)               mem_ready = 1'b1;
            else if (is_mem && c >= mem_lo) mem_ready = (c == mem_hi);
            else                            mem_ready = 1'($urandom);
            zero = (c == exec_c) ? zx : 1'($urandom);
            #1;
            n_rd += int'(memread);
            n_wr += int'(memwrite);
            if ((memread || memwrite) && iord) n_io++;
            n_ir += int'(irwrite);
            if (pcwrite) begin
                n_pc++;
                last_npc = int'(npc_slc);
            end
            if (regwrite) begin
                n_rw++;
                rd_s = int'(regdst);
                wd_s = int'(wd_sel);
            end
            if (c == exec_c && it.kind != K_JMP) begin
                chk({nm, ".alusrc"}, alusrc, it.asrc);
                if (it.chk_aop) chk({nm, ".aluop"}, aluop, it.aop);
                if (it.chk_ext) chk({nm, ".extop"}, extop, it.ext);
            end
        end
        step();
        model_ret++;
        exp_pc  = 1 + ((it.kind == K_JMP) ? 1 : 0) + ((it.kind == K_BEQ && zx) ? 1 : 0);
        exp_npc = (it.kind == K_JMP) ? int'(it.npc) : ((it.kind == K_BEQ && zx) ? 1 : 0);
        exp_rd  = fw + 1 + ((it.kind == K_LW) ? mw + 1 : 0);
        chk({nm, ".end_state"}, state, 0);
        chk({nm, ".fault"}, fault, 0);
        chk({nm, ".retired"}, retired, model_ret % (1 << CW));
        chk({nm, ".memread_cyc"}, n_rd, exp_rd);
        chk({nm, ".memwrite_cyc"}, n_wr, (it.kind == K_SW) ? mw + 1 : 0);
        chk({nm, ".iord_cyc"}, n_io, is_mem ? mw + 1 : 0);
        chk({nm, ".irwrite_cyc"}, n_ir, 1);
        chk({nm, ".pcwrite_cyc"}, n_pc, exp_pc);
        chk({nm, ".npc_last"}, last_npc, exp_npc);
        chk({nm, ".regwrite_cyc"}, n_rw, int'(it.rw));
        if (it.rw) begin
            chk({nm, ".regdst"}, rd_s, it.rd);
            chk({nm, ".wd_sel"}, wd_s, it.wd);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] tr_st [5];
        logic       tr_rw [5];
        int         quiet;
        dvec_t      d;

        itab[0]  = '{6'h00, 6'h21, K_ALU, 1'b1, 2'b01, 2'b00, 3'd0, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0};
        itab[1]  = '{6'h00, 6'h23, K_ALU, 1'b1, 2'b01, 2'b00, 3'd0, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0};
        itab[2]  = '{6'h00, 6'h03, K_ALU, 1'b1, 2'b01, 2'b00, 3'd0, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0};
        itab[3]  = '{6'h0D, 6'h00, K_ALU, 1'b1, 2'b00, 2'b00, 3'd0, 3'b001, 1'b1, 1'b1, 1'b0, 1'b1};
        itab[4]  = '{6'h0F, 6'h00, K_ALU, 1'b1, 2'b00, 2'b11, 3'd0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0};
        itab[5]  = '{6'h23, 6'h00, K_LW,  1'b1, 2'b00, 2'b01, 3'd0, 3'b010, 1'b1, 1'b1, 1'b1, 1'b1};
        itab[6]  = '{6'h2B, 6'h00, K_SW,  1'b0, 2'b00, 2'b00, 3'd0, 3'b010, 1'b1, 1'b1, 1'b1, 1'b1};
        itab[7]  = '{6'h04, 6'h00, K_BEQ, 1'b0, 2'b00, 2'b00, 3'd1, 3'b011, 1'b1, 1'b0, 1'b1, 1'b1};
        itab[8]  = '{6'h02, 6'h00, K_JMP, 1'b0, 2'b00, 2'b00, 3'd2, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
        itab[9]  = '{6'h03, 6'h00, K_JMP, 1'b1, 2'b10, 2'b10, 3'd3, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
        itab[10] = '{6'h00, 6'h08, K_JMP, 1'b0, 2'b00, 2'b00, 3'd4, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
        itab[11] = '{6'h00, 6'h09, K_JMP, 1'b1, 2'b01, 2'b10, 3'd5, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};

        // DECODE-cycle vectors: {opc, func, pcwrite, npc, regwrite, regdst, wd_sel, next state}
        dtab[0]  = '{6'h02, 6'h00, 1'b1, 3'd2, 1'b0, 2'b00, 2'b00, 3'd0};
        dtab[1]  = '{6'h03, 6'h00, 1'b1, 3'd3, 1'b1, 2'b10, 2'b10, 3'd0};
        dtab[2]  = '{6'h00, 6'h08, 1'b1, 3'd4, 1'b0, 2'b00, 2'b00, 3'd0};
        dtab[3]  = '{6'h00, 6'h09, 1'b1, 3'd5, 1'b1, 2'b01, 2'b10, 3'd0};
        dtab[4]  = '{6'h00, 6'h21, 1'b0, 3'd0, 1'b0, 2'b00, 2'b00, 3'd2};
        dtab[5]  = '{6'h23, 6'h00, 1'b0, 3'd0, 1'b0, 2'b00, 2'b00, 3'd2};
        dtab[6]  = '{6'h04, 6'h00, 1'b0, 3'd0, 1'b0, 2'b00, 2'b00, 3'd2};
        dtab[7]  = '{6'h0D, 6'h00, 1'b0, 3'd0, 1'b0, 2'b00, 2'b00, 3'd2};
        dtab[8]  = '{6'h3F, 6'h00, 1'b0, 3'd0, 1'b0, 2'b00, 2'b00, 3'd5};
        dtab[9]  = '{6'h00, 6'h3F, 1'b0, 3'd0, 1'b0, 2'b00, 2'b00, 3'd5};
        dtab[10] = '{6'h00, 6'h20, 1'b0, 3'd0, 1'b0, 2'b00, 2'b00, 3'd5};

        // Reset values, with inputs that would otherwise start a fetch
        rst_n = 1'b0;
        mem_ready = 1'b1;
        #12;
        chk("rst.strobes", strobes(), 0);
        chk("rst.iord", iord, 0);
        chk("rst.npc", npc_slc, 0);
        chk("rst.state", state, 0);
        chk("rst.fault", fault, 0);
        chk("rst.retired", retired, 0);

        // addu trace: states 0,1,2,4 then back to 0, regwrite only in WB
        tr_st = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
        tr_rw = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        opc = 6'h00; func = 6'h21; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("addu_tr.state%0d", i), state, tr_st[i]);
            chk($sformatf("addu_tr.regwrite%0d", i), regwrite, tr_rw[i]);
            if (tr_rw[i]) chk("addu_tr.regdst", regdst, 1);
            step();
        end
        chk("addu_tr.final_state", state, tr_st[4]);
        chk("addu_tr.retired", retired, 1);

        // Table-driven DECODE checks
        for (int i = 0; i < 11; i++) begin
            d = dtab[i];
            do_reset();
            opc = d.opc; func = d.func; mem_ready = 1'b1;
            step();
            chk($sformatf("dec%0d.state", i), state, 1);
            chk($sformatf("dec%0d.pcwrite", i), pcwrite, d.pcw);
            if (d.pcw) chk($sformatf("dec%0d.npc", i), npc_slc, d.npc);
            chk($sformatf("dec%0d.regwrite", i), regwrite, d.rw);
            if (d.rw) begin
                chk($sformatf("dec%0d.regdst", i), regdst, d.rd);
                chk($sformatf("dec%0d.wd_sel", i), wd_sel, d.wd);
            end
            chk($sformatf("dec%0d.mem", i), int'(memread) + int'(memwrite) + int'(irwrite), 0);
            mem_ready = 1'b0;
            step();
            chk($sformatf("dec%0d.next", i), state, d.nxt);
            chk($sformatf("dec%0d.fault", i), fault, (d.nxt == 3'd5) ? 1 : 0);
        end

        // Directed multi-cycle cases: lw with slow memory, beq taken/not taken,
        // fetch ready arriving on the last allowed cycle
        do_reset();
        run_instr(5, 0, 3, 1'b0);
        run_instr(7, 0, 0, 1'b1);
        run_instr(7, 0, 0, 1'b0);
        run_instr(9, 0, 0, 1'b0);
        run_instr(0, TO - 1, 0, 1'b0);
        run_instr(6, 0, TO - 1, 1'b0);

        // Illegal opcode: sticky fault, quiet, not retired; reset recovers
        opc = 6'h3F; mem_ready = 1'b1;
        step();
        step();
        chk("ill.state", state, 5);
        chk("ill.fault", fault, 1);
        quiet = 0;
        for (int i = 0; i < 20; i++) begin
            mem_ready = 1'($urandom);
            zero = 1'($urandom);
            #1;
            quiet += strobes();
            if (state != 3'd5) quiet++;
            step();
        end
        chk("ill.quiet", quiet, 0);
        chk("ill.retired_held", retired, model_ret % (1 << CW));
        do_reset();
        chk("ill.rst_state", state, 0);
        chk("ill.rst_fault", fault, 0);
        chk("ill.rst_retired", retired, 0);

        // Fetch timeout: 14 idle cycles survive, the 15th faults
        do_reset();
        repeat (TO - 1) step();
        chk("fto.state_before", state, 0);
        step();
        chk("fto.state", state, 5);
        chk("fto.fault", fault, 1);

        do_reset();
        repeat (TO - 1) step();
        mem_ready = 1'b1;
        step();
        chk("fto.ready_last", state, 1);

        // MEM timeout on lw
        do_reset();
        opc = 6'h23; mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        step();
        step();
        chk("mto.in_mem", state, 3);
        repeat (TO - 1) step();
        chk("mto.state_before", state, 3);
        chk("mto.rd_iord", int'(memread) + int'(iord), 2);
        step();
        chk("mto.state", state, 5);
        chk("mto.fault", fault, 1);

        // Asynchronous reset in the middle of WB kills the write at once
        do_reset();
        run_instr(1, 0, 0, 1'b0);
        opc = 6'h00; func = 6'h21; mem_ready = 1'b1;
        repeat (3) step();
        chk("arst.wb_regwrite", regwrite, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.regwrite", regwrite, 0);
        chk("arst.state", state, 0);
        chk("arst.retired", retired, 0);
        do_reset();

        // Random instruction stream against the model; retired wraps at 16
        for (int n = 0; n < 60; n++) begin
            int idx, fw, mw;
            idx = int'($urandom_range(0, 11));
            fw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(3, TO - 1)) : int'($urandom_range(0, 2));
            mw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(3, TO - 1)) : int'($urandom_range(0, 2));
            run_instr(idx, fw, mw, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
